// File: rtl/minbd_local_ni.sv
// minbd_local_ni
// Local network interface between a processing core and the local port of a
// MinBD router.
//
// Injection path: the core offers one flit per cycle. Each accepted flit is
// stamped with router header fields and written into a small injection FIFO.
// The FIFO head drives the router local input and is popped on grant.
//
// Ejection path: the router may eject up to two flits per cycle and cannot be
// back-pressured. Flits are written into an ejection FIFO. Any flit that does
// not fit is dropped and recorded in a sticky overflow flag. The core drains
// this FIFO at one flit per cycle.
//
// Flit layout, MSB to LSB:
//   silver(1) pkt_id(6) seq(5) len(3) rsvd(3) dst_x(3) dst_y(3) valid(1) data(WIDTH_DATA)
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   core_inj_valid/ready  core injection handshake
//   core_inj_sop          first flit of a packet (len/dst sampled here)
//   core_inj_len          packet length in flits
//   core_inj_dst_x/y      destination coordinates
//   core_inj_data         payload
//   din_l                 injection FIFO head towards the router ('0 when empty)
//   local_inject_gnt      router consumed din_l this cycle
//   dout_l_1, dout_l_2    ejected flits from the router
//   core_ej_valid/ready   core ejection handshake
//   core_ej_flit          ejection FIFO head ('0 when empty)
//   ej_overflow           sticky flag: an ejected flit was dropped

module minbd_local_ni #(
    parameter int WIDTH_DATA = 32,
    parameter int INJ_DEPTH  = 4,
    parameter int EJ_DEPTH   = 8,
    localparam int WF        = 25 + WIDTH_DATA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_inj_valid,
    output logic                  core_inj_ready,
    input  logic                  core_inj_sop,
    input  logic [2:0]            core_inj_len,
    input  logic [2:0]            core_inj_dst_x,
    input  logic [2:0]            core_inj_dst_y,
    input  logic [WIDTH_DATA-1:0] core_inj_data,
    output logic [WF-1:0]         din_l,
    input  logic                  local_inject_gnt,
    input  logic [WF-1:0]         dout_l_1,
    input  logic [WF-1:0]         dout_l_2,
    output logic                  core_ej_valid,
    input  logic                  core_ej_ready,
    output logic [WF-1:0]         core_ej_flit,
    output logic                  ej_overflow
);

    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int EAW = $clog2(EJ_DEPTH);

    // ------------------------------------------------------------------
    // Injection side
    // ------------------------------------------------------------------
    logic [WF-1:0] inj_mem_r [INJ_DEPTH];
    logic [IAW:0]  inj_wr_ptr_r;
    logic [IAW:0]  inj_rd_ptr_r;
    logic          inj_full_s;
    logic          inj_empty_s;
    logic          inj_push_s;
    logic          inj_pop_s;

    // Header state: next pkt_id to hand out, and the fields of the packet in flight.
    logic [5:0]    pkt_cnt_r;
    logic [5:0]    cur_pkt_r;
    logic [4:0]    seq_nxt_r;
    logic [2:0]    cur_len_r;
    logic [2:0]    cur_dx_r;
    logic [2:0]    cur_dy_r;

    logic [5:0]    stamp_pkt_s;
    logic [4:0]    stamp_seq_s;
    logic [2:0]    stamp_len_s;
    logic [2:0]    stamp_dx_s;
    logic [2:0]    stamp_dy_s;
    logic [WF-1:0] stamp_flit_s;

    assign inj_empty_s    = (inj_wr_ptr_r == inj_rd_ptr_r);
    assign inj_full_s     = (inj_wr_ptr_r[IAW] != inj_rd_ptr_r[IAW]) &&
                            (inj_wr_ptr_r[IAW-1:0] == inj_rd_ptr_r[IAW-1:0]);
    // Ready depends on the registered occupancy only; a same-cycle pop does not free a slot.
    assign core_inj_ready = !inj_full_s;
    assign inj_push_s     = core_inj_valid && !inj_full_s;
    // A grant while the FIFO is empty does nothing.
    assign inj_pop_s      = local_inject_gnt && !inj_empty_s;
    assign din_l          = inj_empty_s ? {WF{1'b0}} : inj_mem_r[inj_rd_ptr_r[IAW-1:0]];

    // Select the header fields for the flit being offered this cycle.
    always_comb begin
        if (core_inj_sop) begin
            stamp_pkt_s = pkt_cnt_r;
            stamp_seq_s = 5'd0;
            stamp_len_s = core_inj_len;
            stamp_dx_s  = core_inj_dst_x;
            stamp_dy_s  = core_inj_dst_y;
        end else begin
            stamp_pkt_s = cur_pkt_r;
            stamp_seq_s = seq_nxt_r;
            stamp_len_s = cur_len_r;
            stamp_dx_s  = cur_dx_r;
            stamp_dy_s  = cur_dy_r;
        end
        stamp_flit_s = {1'b0, stamp_pkt_s, stamp_seq_s, stamp_len_s, 3'd0,
                        stamp_dx_s, stamp_dy_s, 1'b1, core_inj_data};
    end

    // Update the packet counter and in-flight header state on every accepted flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_r <= 6'd0;
            cur_pkt_r <= 6'd0;
            seq_nxt_r <= 5'd0;
            cur_len_r <= 3'd0;
            cur_dx_r  <= 3'd0;
            cur_dy_r  <= 3'd0;
        end else if (inj_push_s) begin
            seq_nxt_r <= stamp_seq_s + 5'd1;
            if (core_inj_sop) begin
                pkt_cnt_r <= pkt_cnt_r + 6'd1;
                cur_pkt_r <= pkt_cnt_r;
                cur_len_r <= core_inj_len;
                cur_dx_r  <= core_inj_dst_x;
                cur_dy_r  <= core_inj_dst_y;
            end
        end
    end

    // Injection FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_wr_ptr_r <= {(IAW+1){1'b0}};
            inj_rd_ptr_r <= {(IAW+1){1'b0}};
        end else begin
            if (inj_push_s) begin
                inj_wr_ptr_r <= inj_wr_ptr_r + (IAW+1)'(1);
            end
            if (inj_pop_s) begin
                inj_rd_ptr_r <= inj_rd_ptr_r + (IAW+1)'(1);
            end
        end
    end

    // Injection FIFO storage. Contents are hidden by the empty check after reset.
    always_ff @(posedge clk) begin
        if (inj_push_s) begin
            inj_mem_r[inj_wr_ptr_r[IAW-1:0]] <= stamp_flit_s;
        end
    end

    // ------------------------------------------------------------------
    // Ejection side
    // ------------------------------------------------------------------
    logic [WF-1:0] ej_mem_r [EJ_DEPTH];
    logic [EAW:0]  ej_wr_ptr_r;
    logic [EAW:0]  ej_rd_ptr_r;
    logic [EAW:0]  ej_occ_s;
    logic [EAW+1:0] ej_free_s;
    logic          ej_empty_s;
    logic          ej_pop_s;
    logic          ej_v1_s;
    logic          ej_v2_s;
    logic          ej_wr0_en_s;
    logic          ej_wr1_en_s;
    logic [WF-1:0] ej_wr0_data_s;
    logic          ej_drop_s;
    logic [EAW:0]  ej_wr_cnt_s;
    logic [EAW-1:0] ej_wr_idx0_s;
    logic [EAW-1:0] ej_wr_idx1_s;
    logic          ej_overflow_r;

    assign ej_empty_s    = (ej_wr_ptr_r == ej_rd_ptr_r);
    assign ej_pop_s      = !ej_empty_s && core_ej_ready;
    assign ej_occ_s      = ej_wr_ptr_r - ej_rd_ptr_r;
    // The slot freed by this cycle's pop can be refilled in the same cycle.
    assign ej_free_s     = (EAW+2)'(EJ_DEPTH) - {1'b0, ej_occ_s} + {{(EAW+1){1'b0}}, ej_pop_s};
    assign ej_v1_s       = dout_l_1[WIDTH_DATA];
    assign ej_v2_s       = dout_l_2[WIDTH_DATA];
    assign ej_wr_idx0_s  = ej_wr_ptr_r[EAW-1:0];
    assign ej_wr_idx1_s  = ej_wr_ptr_r[EAW-1:0] + EAW'(1);
    assign ej_wr_cnt_s   = {{EAW{1'b0}}, ej_wr0_en_s} + {{EAW{1'b0}}, ej_wr1_en_s};
    assign core_ej_valid = !ej_empty_s;
    assign core_ej_flit  = ej_empty_s ? {WF{1'b0}} : ej_mem_r[ej_rd_ptr_r[EAW-1:0]];
    assign ej_overflow   = ej_overflow_r;

    // Decide which ejected flits are stored. Port 1 has priority when only one slot is left.
    always_comb begin
        ej_wr0_en_s   = 1'b0;
        ej_wr1_en_s   = 1'b0;
        ej_wr0_data_s = dout_l_1;
        ej_drop_s     = 1'b0;
        case ({ej_v1_s, ej_v2_s})
            2'b11: begin
                if (ej_free_s >= (EAW+2)'(2)) begin
                    ej_wr0_en_s = 1'b1;
                    ej_wr1_en_s = 1'b1;
                end else if (ej_free_s >= (EAW+2)'(1)) begin
                    ej_wr0_en_s = 1'b1;
                    ej_drop_s   = 1'b1;
                end else begin
                    ej_drop_s   = 1'b1;
                end
            end
            2'b10: begin
                if (ej_free_s >= (EAW+2)'(1)) begin
                    ej_wr0_en_s = 1'b1;
                end else begin
                    ej_drop_s   = 1'b1;
                end
            end
            2'b01: begin
                ej_wr0_data_s = dout_l_2;
                if (ej_free_s >= (EAW+2)'(1)) begin
                    ej_wr0_en_s = 1'b1;
                end else begin
                    ej_drop_s   = 1'b1;
                end
            end
            default: begin
                ej_wr0_en_s = 1'b0;
            end
        endcase
    end

    // Ejection FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ej_wr_ptr_r   <= {(EAW+1){1'b0}};
            ej_rd_ptr_r   <= {(EAW+1){1'b0}};
            ej_overflow_r <= 1'b0;
        end else begin
            ej_wr_ptr_r <= ej_wr_ptr_r + ej_wr_cnt_s;
            if (ej_pop_s) begin
                ej_rd_ptr_r <= ej_rd_ptr_r + (EAW+1)'(1);
            end
            if (ej_drop_s) begin
                ej_overflow_r <= 1'b1;
            end
        end
    end

    // Ejection FIFO storage; the second slot is only used when both ports are stored.
    always_ff @(posedge clk) begin
        if (ej_wr0_en_s) begin
            ej_mem_r[ej_wr_idx0_s] <= ej_wr0_data_s;
        end
        if (ej_wr1_en_s) begin
            ej_mem_r[ej_wr_idx1_s] <= dout_l_2;
        end
    end

endmodule

// File: tb/tb_minbd_local_ni.sv
module tb_minbd_local_ni;

    localparam int WD = 32;
    localparam int WF = 25 + WD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_inj_valid = 1'b0;
    logic          core_inj_ready;
    logic          core_inj_sop = 1'b0;
    logic [2:0]    core_inj_len = 3'd0;
    logic [2:0]    core_inj_dst_x = 3'd0;
    logic [2:0]    core_inj_dst_y = 3'd0;
    logic [WD-1:0] core_inj_data = '0;
    logic [WF-1:0] din_l;
    logic          local_inject_gnt = 1'b0;
    logic [WF-1:0] dout_l_1 = '0;
    logic [WF-1:0] dout_l_2 = '0;
    logic          core_ej_valid;
    logic          core_ej_ready = 1'b0;
    logic [WF-1:0] core_ej_flit;
    logic          ej_overflow;

    int errors = 0;
    int checks = 0;
    int ej_pops = 0;
    int ej_base;
    logic [WF-1:0] inj_q [$];
    logic [WF-1:0] ej_q [$];
    logic [WF-1:0] fa;
    logic [WF-1:0] fb;

    minbd_local_ni #(.WIDTH_DATA(WD), .INJ_DEPTH(4), .EJ_DEPTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .core_inj_valid   (core_inj_valid),
        .core_inj_ready   (core_inj_ready),
        .core_inj_sop     (core_inj_sop),
        .core_inj_len     (core_inj_len),
        .core_inj_dst_x   (core_inj_dst_x),
        .core_inj_dst_y   (core_inj_dst_y),
        .core_inj_data    (core_inj_data),
        .din_l            (din_l),
        .local_inject_gnt (local_inject_gnt),
        .dout_l_1         (dout_l_1),
        .dout_l_2         (dout_l_2),
        .core_ej_valid    (core_ej_valid),
        .core_ej_ready    (core_ej_ready),
        .core_ej_flit     (core_ej_flit),
        .ej_overflow      (ej_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [WF-1:0] mk_flit(input logic [5:0] pkt, input logic [4:0] seq,
                                              input logic [2:0] len, input logic [2:0] dx,
                                              input logic [2:0] dy, input logic [WD-1:0] data);
        return {1'b0, pkt, seq, len, 3'b000, dx, dy, 1'b1, data};
    endfunction

    task automatic check(input string name, input logic [WF-1:0] act, input logic [WF-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sop, input logic [2:0] len, input logic [2:0] dx,
                        input logic [2:0] dy, input logic [WD-1:0] data,
                        input logic [WF-1:0] exp, input bit track);
        core_inj_valid = 1'b1;
        core_inj_sop   = sop;
        core_inj_len   = len;
        core_inj_dst_x = dx;
        core_inj_dst_y = dy;
        core_inj_data  = data;
        if (track) inj_q.push_back(exp);
        tick();
        core_inj_valid = 1'b0;
        core_inj_sop   = 1'b0;
    endtask

    task automatic eject(input logic [WF-1:0] f1, input logic [WF-1:0] f2,
                         input bit exp1, input bit exp2);
        dout_l_1 = f1;
        dout_l_2 = f2;
        if (exp1) ej_q.push_back(f1);
        if (exp2) ej_q.push_back(f2);
        tick();
        dout_l_1 = '0;
        dout_l_2 = '0;
    endtask

    // Monitor: compares router-side and core-side outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (din_l[WD]) begin
                if (local_inject_gnt) begin
                    if (inj_q.size() == 0) begin
                        check("inj_unexpected", din_l, '0);
                    end else begin
                        check("inj_flit", din_l, inj_q.pop_front());
                    end
                end
            end else begin
                check("din_l_idle_zero", din_l, '0);
            end
            if (core_ej_valid && core_ej_ready) begin
                ej_pops++;
                if (ej_q.size() == 0) begin
                    check("ej_unexpected", core_ej_flit, '0);
                end else begin
                    check("ej_flit", core_ej_flit, ej_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        #3;
        check("rst_din_l", din_l, '0);
        check("rst_ej_valid", WF'(core_ej_valid), '0);
        check("rst_ej_flit", core_ej_flit, '0);
        check("rst_overflow", WF'(ej_overflow), '0);
        check("rst_inj_ready", WF'(core_inj_ready), WF'(1));
        tick();
        rst = 1'b0;
        tick();

        // Two-flit packet held by gnt=0, then granted
        fa = mk_flit(6'd0, 5'd0, 3'd2, 3'd3, 3'd2, 32'hA);
        fb = mk_flit(6'd0, 5'd1, 3'd2, 3'd3, 3'd2, 32'hB);
        push(1'b1, 3'd2, 3'd3, 3'd2, 32'hA, fa, 1'b1);
        check("pkt_head_latency", din_l, fa);
        push(1'b0, 3'd0, 3'd0, 3'd0, 32'hB, fb, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("pkt_head_hold", din_l, fa);
            tick();
        end
        local_inject_gnt = 1'b1;
        tick();
        check("pkt_second_flit", din_l, fb);
        tick();
        local_inject_gnt = 1'b0;

        // Fill the injection FIFO, single grant, fifth flit
        for (int i = 1; i <= 4; i++) begin
            push(1'b1, 3'd1, 3'd1, 3'd1, 32'h30 + i,
                 mk_flit(6'(i), 5'd0, 3'd1, 3'd1, 3'd1, 32'h30 + i), 1'b1);
        end
        check("inj_full_ready", WF'(core_inj_ready), '0);
        local_inject_gnt = 1'b1;
        tick();
        local_inject_gnt = 1'b0;
        check("inj_ready_after_pop", WF'(core_inj_ready), WF'(1));
        push(1'b1, 3'd1, 3'd1, 3'd1, 32'h35, mk_flit(6'd5, 5'd0, 3'd1, 3'd1, 3'd1, 32'h35), 1'b1);
        local_inject_gnt = 1'b1;
        repeat (6) tick();
        local_inject_gnt = 1'b0;

        // Dual ejection with core ready
        core_ej_ready = 1'b1;
        eject(mk_flit(6'd9, 5'd0, 3'd1, 3'd0, 3'd0, 32'h1),
              mk_flit(6'd9, 5'd0, 3'd1, 3'd0, 3'd0, 32'h2), 1'b1, 1'b1);
        repeat (3) tick();
        check("ej_no_overflow", WF'(ej_overflow), '0);

        // Fill seven entries, then overflow with one slot free
        core_ej_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eject(mk_flit(6'd9, 5'd0, 3'd1, 3'd0, 3'd0, 32'h11 + 2 * i),
                  mk_flit(6'd9, 5'd0, 3'd1, 3'd0, 3'd0, 32'h12 + 2 * i), 1'b1, 1'b1);
        end
        eject('0, mk_flit(6'd9, 5'd0, 3'd1, 3'd0, 3'd0, 32'h17), 1'b0, 1'b1);
        check("ej_overflow_before", WF'(ej_overflow), '0);
        eject(mk_flit(6'd9, 5'd0, 3'd1, 3'd0, 3'd0, 32'h7),
              mk_flit(6'd9, 5'd0, 3'd1, 3'd0, 3'd0, 32'h8), 1'b1, 1'b0);
        check("ej_overflow_set", WF'(ej_overflow), WF'(1));
        repeat (2) tick();
        check("ej_overflow_sticky", WF'(ej_overflow), WF'(1));
        ej_base = ej_pops;
        core_ej_ready = 1'b1;
        repeat (10) tick();
        check("ej_drain_count", WF'(ej_pops - ej_base), WF'(8));
        check("ej_overflow_after_drain", WF'(ej_overflow), WF'(1));

        // Reset mid-operation with data buffered on both sides
        core_ej_ready = 1'b0;
        push(1'b1, 3'd1, 3'd4, 3'd4, 32'hDEAD, '0, 1'b0);
        push(1'b1, 3'd1, 3'd4, 3'd4, 32'hBEEF, '0, 1'b0);
        eject(mk_flit(6'd9, 5'd0, 3'd1, 3'd0, 3'd0, 32'h55),
              mk_flit(6'd9, 5'd0, 3'd1, 3'd0, 3'd0, 32'h66), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_din_l", din_l, '0);
        check("midrst_ej_valid", WF'(core_ej_valid), '0);
        check("midrst_overflow", WF'(ej_overflow), '0);
        check("midrst_inj_ready", WF'(core_inj_ready), WF'(1));
        tick();
        rst = 1'b0;

        // 65 single-flit packets: pkt_id 0..63 then wraps to 0
        local_inject_gnt = 1'b1;
        for (int i = 0; i < 65; i++) begin
            push(1'b1, 3'd1, 3'd2, 3'd5, 32'h1000 + i,
                 mk_flit(6'(i % 64), 5'd0, 3'd1, 3'd2, 3'd5, 32'h1000 + i), 1'b1);
        end
        repeat (4) tick();
        local_inject_gnt = 1'b0;
        tick();

        check("inj_queue_drained", WF'(inj_q.size()), '0);
        check("ej_queue_drained", WF'(ej_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
